// File: rtl/seven_seg_pkg.sv
// Shared scan-state encoding, default geometry/timing constants and a BCD validity helper
// for the seven-segment scan controller.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    S_OFF,
    S_ON,
    S_GUARD
  } scan_state_e;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_ON_CYCLES    = 1000;
  localparam int DEF_GUARD_CYCLES = 2;

  function automatic logic bcd_invalid(input logic [3:0] nib);
    return nib > 4'd9;
  endfunction

endpackage

// File: rtl/BCD_7segment.sv
// Combinational BCD to seven-segment decoder, seg[6:0] = {g,f,e,d,c,b,a}, active-high.
// Non-BCD codes decode to a lone middle bar so bad data is visible on the display.
module BCD_7segment (
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b1000000;
    case (i_bcd)
      4'd0: o_seg = 7'b0111111;
      4'd1: o_seg = 7'b0000110;
      4'd2: o_seg = 7'b1011011;
      4'd3: o_seg = 7'b1001111;
      4'd4: o_seg = 7'b1100110;
      4'd5: o_seg = 7'b1101101;
      4'd6: o_seg = 7'b1111101;
      4'd7: o_seg = 7'b0000111;
      4'd8: o_seg = 7'b1111111;
      4'd9: o_seg = 7'b1101111;
      default: o_seg = 7'b1000000;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner: one shared decoder, ON/GUARD phases per digit, outputs combinational
// from registered state; a one-word pending buffer (ready = buffer empty) swaps in only at frame end.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int ON_CYCLES    = DEF_ON_CYCLES,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [4*NUM_DIGITS-1:0]       load_data,
  input  logic                          blank_lz,
  output logic [6:0]                    seg_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          bcd_err
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int MAX_CYC = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

  scan_state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] r_active, r_pend;
  logic                    r_pend_vld;
  logic                    r_bcd_err;

  logic                    w_accept;
  logic                    w_transfer;
  logic                    w_load_bad;
  logic                    w_lz_run;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [3:0]              w_cur_nib;
  logic [6:0]              w_seg;

  assign load_ready = !r_pend_vld;
  assign w_accept   = load_valid && load_ready;
  assign w_transfer = (r_state == S_GUARD) && (r_cnt == '0) && (r_idx == LAST_IDX) && r_pend_vld;
  assign digit_idx  = r_idx;
  assign bcd_err    = r_bcd_err;

  always_comb begin
    w_load_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_load_bad = w_load_bad | bcd_invalid(load_data[4*i +: 4]);
    end
  end

  // A digit is blanked while it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    w_blank  = '0;
    w_lz_run = blank_lz;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_lz_run   = w_lz_run && (r_active[4*i +: 4] == 4'd0);
      w_blank[i] = w_lz_run;
    end
  end

  assign w_cur_nib = r_active[{r_idx, 2'b00} +: 4];

  BCD_7segment u_dec (
    .i_bcd (w_cur_nib),
    .o_seg (w_seg)
  );

  assign seg_out = w_seg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    an_out      = '1;
    case (r_state)
      S_OFF: begin
        if (w_accept) begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = ON_LOAD;
          w_idx_nxt   = '0;
        end
      end
      S_ON: begin
        if (!w_blank[r_idx]) an_out[r_idx] = 1'b0;
        if (r_cnt == '0) begin
          w_state_nxt = S_GUARD;
          w_cnt_nxt   = GUARD_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_GUARD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = ON_LOAD;
          w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_OFF;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Accept and transfer never coincide: transfer needs a full buffer, which holds ready low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active   <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_bcd_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_state == S_OFF) begin
          r_active <= load_data;
        end else begin
          r_pend     <= load_data;
          r_pend_vld <= 1'b1;
        end
        if (w_load_bad) r_bcd_err <= 1'b1;
      end
      if (w_transfer) begin
        r_active   <= r_pend;
        r_pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl (4 digits, 4 on-cycles, 1 guard cycle); outputs sampled on the falling edge.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        blank_lz;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic [1:0]  digit_idx;
  logic        bcd_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .ON_CYCLES    (4),
    .GUARD_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank_lz   (blank_lz),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .digit_idx  (digit_idx),
    .bcd_err    (bcd_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference segment table, {g,f,e,d,c,b,a} active-high; non-BCD shows the middle bar.
  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    load_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_load(input logic [15:0] w);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = w;
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  // Checks one full frame of w. mid_load offers mid_word at digit 1 and a second (stalled) word at digit 2;
  // poke_xfer offers a word on the frame's final guard cycle, which must be refused.
  task automatic run_frame(input logic [15:0] w, input logic blz, input logic mid_load,
                           input logic [15:0] mid_word, input logic poke_xfer);
    logic [3:0] nib;
    logic       lit;
    logic [3:0] exp_an;
    for (int d = 0; d < 4; d++) begin
      nib = w[4*d +: 4];
      lit = 1'b1;
      if (blz && d != 0) begin
        lit = 1'b0;
        for (int k = d; k < 4; k++) if (w[4*k +: 4] != 4'd0) lit = 1'b1;
      end
      exp_an = lit ? ~(4'b0001 << d) : 4'b1111;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("an_on", 32'(an_out), 32'(exp_an));
        chk("digit_idx", 32'(digit_idx), d);
        if (lit) chk("seg", 32'(seg_out), 32'(exp_seg(nib)));
        if (d == 0 && c == 0) begin
          chk("rdy_frame_start", 32'(load_ready), 1);
          load_valid = 1'b0;
        end
        if (mid_load && d == 1 && c == 0) begin
          load_valid = 1'b1;
          load_data  = mid_word;
        end
        if (mid_load && d == 1 && c == 1) begin
          chk("rdy_drop", 32'(load_ready), 0);
          load_valid = 1'b0;
        end
        if (mid_load && d == 2 && c == 0) begin
          load_valid = 1'b1;
          load_data  = 16'h4321;
        end
        if (mid_load && d == 2 && c == 1) load_valid = 1'b0;
      end
      @(negedge clk);
      chk("an_guard", 32'(an_out), 32'hF);
      if (d == 3 && mid_load) chk("rdy_held", 32'(load_ready), 0);
      if (d == 3 && poke_xfer) begin
        load_valid = 1'b1;
        load_data  = 16'h9999;
      end
    end
  endtask

  initial begin
    logic found;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    blank_lz   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    chk("rst_an", 32'(an_out), 32'hF);
    chk("rst_rdy", 32'(load_ready), 1);
    chk("rst_err", 32'(bcd_err), 0);
    chk("rst_idx", 32'(digit_idx), 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_an", 32'(an_out), 32'hF);
      chk("idle_rdy", 32'(load_ready), 1);
    end

    // Plain scan, then a mid-frame reload that must not tear the frame
    do_load(16'h1234);
    chk("err_valid_load", 32'(bcd_err), 0);
    run_frame(16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0);
    run_frame(16'h1234, 1'b0, 1'b1, 16'h5678, 1'b1);
    run_frame(16'h5678, 1'b0, 1'b0, 16'h0000, 1'b0);
    run_frame(16'h5678, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Leading-zero blanking
    do_reset();
    blank_lz = 1'b1;
    do_load(16'h0070);
    run_frame(16'h0070, 1'b1, 1'b1, 16'h0000, 1'b0);
    run_frame(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    blank_lz = 1'b0;
    run_frame(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Invalid nibble: sticky error, still scanned
    do_reset();
    chk("err_cleared", 32'(bcd_err), 0);
    do_load(16'h00A1);
    chk("err_set", 32'(bcd_err), 1);
    run_frame(16'h00A1, 1'b0, 1'b1, 16'h0005, 1'b0);
    run_frame(16'h0005, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("err_sticky", 32'(bcd_err), 1);
    do_reset();
    chk("err_rst", 32'(bcd_err), 0);

    // Reset mid-scan with a pending word
    do_load(16'h1234);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 16'h5B78;
    @(negedge clk);
    load_valid = 1'b0;
    chk("pend_rdy", 32'(load_ready), 0);
    chk("pend_err", 32'(bcd_err), 1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (digit_idx == 2'd2 && an_out == 4'b1011) found = 1'b1;
    end
    chk("reach_digit2", 32'(found), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_rst_an", 32'(an_out), 32'hF);
    chk("mid_rst_rdy", 32'(load_ready), 1);
    chk("mid_rst_err", 32'(bcd_err), 0);
    chk("mid_rst_idx", 32'(digit_idx), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_an", 32'(an_out), 32'hF);
    end
    do_load(16'h0008);
    run_frame(16'h0008, 1'b0, 1'b0, 16'h0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 The block SHALL use one clock with a synchronous, active-low reset: ports clk and rst_n; the polarity and synchronicity are fixed.
REQ-002 The block SHALL take these parameters:
- NUM_DIGITS, 4: number of multiplexed digits, range 2..8.
- ON_CYCLES, 1000: clk cycles each digit is lit, at least 1.
- GUARD_CYCLES, 2: clk cycles with all anodes off between digits (anti-ghosting), at least 1.
REQ-003 The block SHALL have these ports:
- clk, in, 1: clock.
- rst_n, in, 1: sync active-low reset.
- load_valid, in, 1: new display word offered.
- load_ready, out, 1: word accepted when valid&&ready.
- load_data, in, 4*NUM_DIGITS: BCD digits; digit 0 is the LSB nibble.
- blank_lz, in, 1: leading-zero blanking enable.
- seg_out, out, 7: segment pattern of the current digit.
- an_out, out, NUM_DIGITS: digit enables, active-low.
- digit_idx, out, clog2(NUM_DIGITS): index of the currently scanned digit.
- bcd_err, out, 1: sticky flag, set when an accepted nibble is greater than 9.

Function
REQ-004 The block SHALL use three FSM states:
- S_OFF: after reset, nothing lit.
- S_ON: digit digit_idx lit for ON_CYCLES.
- S_GUARD: all anodes high for GUARD_CYCLES.
REQ-005 S_OFF SHALL go to S_ON (digit_idx=0) the cycle after the first accepted load; that load writes the active register directly.
REQ-006 S_ON SHALL go to S_GUARD after exactly ON_CYCLES cycles; S_GUARD SHALL go to S_ON after exactly GUARD_CYCLES cycles, with digit_idx incremented and wrapping from NUM_DIGITS-1 to 0.
REQ-007 A single down-counter SHALL time both states; it reloads on every state entry.
REQ-008 A one-entry pending buffer SHALL hold each load accepted in S_ON or S_GUARD; load_ready = !pending_valid.
REQ-009 The pending word SHALL transfer to the active register only on the last S_GUARD cycle with digit_idx=NUM_DIGITS-1, so a frame is never torn.
REQ-010 A load offered on the transfer cycle SHALL NOT be accepted; load_ready SHALL rise on the following cycle.
REQ-011 A second load while the buffer is full SHALL be stalled (ready=0), never overwritten.
REQ-012 The BCD decoder SHALL be driven from the registered active nibble[digit_idx]; seg_out SHALL be the decoder output unmodified, valid in the same cycle as an_out.
REQ-013 In S_ON, an_out SHALL be low only on bit digit_idx; in S_OFF and S_GUARD, an_out SHALL be all ones.
REQ-014 When blank_lz=1, a digit SHALL be suppressed (anode high) if it and all higher digits are 0; digit 0 is never suppressed. blank_lz is sampled every cycle.
REQ-015 An invalid nibble (greater than 9) SHALL still be scanned with the decoder's invalid pattern, and SHALL set bcd_err at acceptance.
REQ-016 bcd_err SHALL clear only on reset.

Reset
REQ-017 While rst_n=0 at a clk edge, the block SHALL clear:
- state = S_OFF, digit_idx = 0, counter = 0.
- an_out = all ones.
- active register and pending buffer = 0, pending_valid = 0.
- bcd_err = 0.
- load_ready = 1 from the first cycle after reset.
REQ-018 A reset mid-scan or mid-transfer SHALL discard the pending and active words; no digit stays lit.

Structure
REQ-019 Package seven_seg_pkg SHALL hold the scan_state_e enum (S_OFF, S_ON, S_GUARD) and the default parameter constants.
REQ-020 The existing BCD_7segment decoder SHALL be instantiated once as the sole sub-module; it is shared by time multiplexing, not replicated.

Verification
All scenarios use NUM_DIGITS=4, ON_CYCLES=4, GUARD_CYCLES=1.
REQ-021 Reset, then no load for 50 cycles -> an_out=4'b1111 and load_ready=1 throughout.
REQ-022 Load 16'h1234 -> an_out cycles 1110, 1111, 1101, 1111, 1011, 1111, 0111, 1111; each lit phase lasts 4 cycles; seg_out matches the decoder for 4, 3, 2, 1 respectively.
REQ-023 During a scan of 16'h1234, load 16'h5678 at digit 1 -> load_ready drops; 1234 completes the frame; the next frame shows 5678; ready rises after the transfer.
REQ-024 blank_lz=1 with 16'h0070 -> digits 3 and 2 stay dark; digits 1 (7) and 0 (0) are lit. Load 16'h0000 -> only digit 0 is lit.
REQ-025 Load 16'h00A1 -> bcd_err=1 the next cycle, the invalid digit is still scanned, and bcd_err stays 1 until reset.
REQ-026 Assert rst_n=0 for 1 cycle during S_ON of digit 2 with a load pending -> the next cycle shows S_OFF, an_out=1111, pending cleared, bcd_err=0.
